// File: rtl/sound_fx.sv
// Event-driven square-wave sound generator: wall / paddle / point tone patterns.
// Optional `SOUND_FX_MUTE_EN adds a `mute` input that gates the speaker output.
module sound_fx #(
  parameter int unsigned PRESCALE   = 10000,
  parameter int unsigned WALL_HALF  = 11364,
  parameter int unsigned HIT_HALF   = 5682,
  parameter int unsigned POINT_HALF = 22727,
  parameter int unsigned WALL_MS    = 20,
  parameter int unsigned HIT_MS     = 40,
  parameter int unsigned POINT_MS   = 120,
  parameter int unsigned GAP_MS     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_wall,
  input  logic       ev_hit,
  input  logic       ev_point,
`ifdef SOUND_FX_MUTE_EN
  input  logic       mute,
`endif
  output logic       speaker,
  output logic       busy,
  output logic [1:0] sound_id
);

  typedef enum logic [1:0] {IDLE, TONE1, GAP, TONE2} state_t;

  state_t      state, state_nxt;
  logic [2:0]  sync1, sync2, prev, rise;
  logic [13:0] pre_cnt;
  logic [15:0] tone_cnt, half;
  logic [7:0]  ms_cnt, dur;
  logic [1:0]  id, id_nxt, ev_id;
  logic        spk_q, tick, done, accept, tone_wrap, tone_clr;

  // History flops reset high so a level held across reset is not seen as a rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {ev_point, ev_hit, ev_wall};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  always_comb begin
    ev_id     = 2'd0;
    dur       = 8'(POINT_MS);
    half      = 16'(WALL_HALF);
    state_nxt = state;
    id_nxt    = id;
    accept    = 1'b0;

    if (rise[2])      ev_id = 2'd3;
    else if (rise[1]) ev_id = 2'd2;
    else if (rise[0]) ev_id = 2'd1;

    case (id)
      2'd3:    half = 16'(POINT_HALF);
      2'd2:    half = 16'(HIT_HALF);
      default: half = 16'(WALL_HALF);
    endcase

    case (state)
      TONE1: begin
        case (id)
          2'd3:    dur = 8'(POINT_MS);
          2'd2:    dur = 8'(HIT_MS);
          default: dur = 8'(WALL_MS);
        endcase
      end
      GAP:     dur = 8'(GAP_MS);
      default: dur = 8'(POINT_MS);
    endcase

    tick      = (pre_cnt == 14'(PRESCALE - 1));
    done      = (state != IDLE) && tick && (ms_cnt + 8'd1 == dur);
    tone_wrap = (tone_cnt == half - 16'd1);

    if (done) begin
      case (state)
        TONE1:   state_nxt = (id == 2'd3) ? GAP : IDLE;
        GAP:     state_nxt = TONE2;
        TONE2:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    if (state_nxt == IDLE) id_nxt = 2'd0;

    // Comparing against the post-transition id lets an event on the exit edge win.
    if (ev_id > id_nxt) begin
      accept    = 1'b1;
      state_nxt = TONE1;
      id_nxt    = ev_id;
    end

    tone_clr = accept || (state_nxt != state) || (state_nxt == IDLE) || (state_nxt == GAP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      id       <= '0;
      pre_cnt  <= '0;
      ms_cnt   <= '0;
      tone_cnt <= '0;
      spk_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      id    <= id_nxt;

      if (accept || state_nxt == IDLE) pre_cnt <= '0;
      else if (tick)                   pre_cnt <= '0;
      else                             pre_cnt <= pre_cnt + 14'd1;

      if (accept || state_nxt != state) ms_cnt <= '0;
      else if (tick)                    ms_cnt <= ms_cnt + 8'd1;

      if (tone_clr) begin
        tone_cnt <= '0;
        spk_q    <= 1'b0;
      end else if (tone_wrap) begin
        tone_cnt <= '0;
        spk_q    <= ~spk_q;
      end else begin
        tone_cnt <= tone_cnt + 16'd1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign sound_id = id;

`ifdef SOUND_FX_MUTE_EN
  assign speaker = spk_q & ~mute;
`else
  assign speaker = spk_q;
`endif

endmodule

// File: tb/tb_sound_fx.sv
// Directed bench for sound_fx with scaled-down timing parameters.
module tb_sound_fx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ev_wall = 1'b0, ev_hit = 1'b0, ev_point = 1'b0;
  logic       mute = 1'b0;
  logic       speaker, busy;
  logic [1:0] sound_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sound_fx #(
    .PRESCALE(10), .WALL_HALF(2), .HIT_HALF(3), .POINT_HALF(5),
    .WALL_MS(2), .HIT_MS(4), .POINT_MS(3), .GAP_MS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ev_wall(ev_wall),
    .ev_hit(ev_hit),
    .ev_point(ev_point),
`ifdef SOUND_FX_MUTE_EN
    .mute(mute),
`endif
    .speaker(speaker),
    .busy(busy),
    .sound_id(sound_id)
  );

  typedef struct {
    logic       w;
    logic       h;
    logic       p;
    logic [1:0] exp_id;
    int         dur;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected speaker level t cycles after the accept edge.
  function automatic logic exp_spk(input logic [1:0] id, input int t);
    case (id)
      2'd1:    return logic'((t / 2) % 2);
      2'd2:    return logic'((t / 3) % 2);
      2'd3: begin
        if (t < 30)      return logic'((t / 5) % 2);
        else if (t < 50) return 1'b0;
        else             return logic'(((t - 50) / 5) % 2);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_cycle(input logic [1:0] id, input int t, input int dur);
    if (t >= dur) begin
      chk($sformatf("busy_end id%0d t%0d", id, t), {1'b0, busy}, 2'd0);
      chk($sformatf("id_end id%0d t%0d", id, t), sound_id, 2'd0);
      chk($sformatf("spk_end id%0d t%0d", id, t), {1'b0, speaker}, 2'd0);
    end else begin
      chk($sformatf("busy id%0d t%0d", id, t), {1'b0, busy}, 2'd1);
      chk($sformatf("id id%0d t%0d", id, t), sound_id, id);
      chk($sformatf("spk id%0d t%0d", id, t), {1'b0, speaker},
          {1'b0, exp_spk(id, t) & ~mute});
    end
  endtask

  task automatic settle();
    ev_wall  = 1'b0;
    ev_hit   = 1'b0;
    ev_point = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    ev_wall  = v.w;
    ev_hit   = v.h;
    ev_point = v.p;
    @(negedge clk);
    chk("latency edge k", {1'b0, busy}, 2'd0);
    @(negedge clk);
    chk("latency edge k+1", {1'b0, busy}, 2'd0);
    for (int t = 0; t <= v.dur; t++) begin
      @(negedge clk);
      check_cycle(v.exp_id, t, v.dur);
    end
    settle();
  endtask

  initial begin
    vecs[0] = '{w: 1'b1, h: 1'b0, p: 1'b0, exp_id: 2'd1, dur: 20};
    vecs[1] = '{w: 1'b0, h: 1'b1, p: 1'b0, exp_id: 2'd2, dur: 40};
    vecs[2] = '{w: 1'b0, h: 1'b0, p: 1'b1, exp_id: 2'd3, dur: 80};
    vecs[3] = '{w: 1'b1, h: 1'b1, p: 1'b0, exp_id: 2'd2, dur: 40};
    vecs[4] = '{w: 1'b1, h: 1'b1, p: 1'b1, exp_id: 2'd3, dur: 80};
    vecs[5] = '{w: 1'b0, h: 1'b1, p: 1'b1, exp_id: 2'd3, dur: 80};

    // Reset with ev_wall held high; release must not trigger.
    reset   = 1'b0;
    ev_wall = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", {1'b0, busy}, 2'd0);
    chk("reset id", sound_id, 2'd0);
    chk("reset spk", {1'b0, speaker}, 2'd0);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk($sformatf("held-high no trigger c%0d", i), {1'b0, busy}, 2'd0);
    end
    settle();

    for (int unsigned i = 0; i < 6; i++) run_vec(vecs[i]);

    // Wall preempted by hit; a later wall edge during hit is dropped.
    ev_wall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int t = 0; t <= 4; t++) begin
      @(negedge clk);
      check_cycle(2'd1, t, 20);
      if (t == 2) ev_hit = 1'b1;
    end
    for (int t = 0; t <= 50; t++) begin
      @(negedge clk);
      check_cycle(2'd2, t, 40);
      if (t == 10) ev_wall = 1'b0;
      if (t == 15) ev_wall = 1'b1;
    end
    settle();

    // Reset mid-point while ev_point stays high.
    ev_point = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int t = 0; t <= 27; t++) begin
      @(negedge clk);
      check_cycle(2'd3, t, 80);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midreset busy", {1'b0, busy}, 2'd0);
    chk("midreset id", sound_id, 2'd0);
    chk("midreset spk", {1'b0, speaker}, 2'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset idle c%0d", i), {1'b0, busy}, 2'd0);
    end
    settle();

`ifdef SOUND_FX_MUTE_EN
    mute = 1'b1;
    run_vec(vecs[1]);
    mute = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
